// File: rtl/csr_trap_sequencer_if.sv
// Bus between the trap sequencer and its neighbours: commit/exception logic,
// the CSR execution unit, the CSR file and fetch redirect.
interface csr_trap_sequencer_if #(parameter int XLEN = 64);
    logic            trap_valid_in;
    logic [XLEN-1:0] trap_pc_in;
    logic [XLEN-1:0] trap_cause_in;
    logic [XLEN-1:0] trap_tval_in;
    logic            trap_ready_out;
    logic            mret_valid_in;
    logic            mret_ready_out;
    logic [11:0]     csru_read_name_in;
    logic [XLEN-1:0] csru_read_data_out;
    logic            csru_write_valid_in;
    logic [11:0]     csru_write_name_in;
    logic [XLEN-1:0] csru_write_data_in;
    logic            csru_stall_out;
    logic            csru_conflict_out;
    logic [11:0]     csr_read_name_out;
    logic [XLEN-1:0] csr_read_data_in;
    logic            csr_write_valid_out;
    logic [11:0]     csr_write_name_out;
    logic [XLEN-1:0] csr_write_data_out;
    logic            redirect_valid_out;
    logic [XLEN-1:0] redirect_addr_out;
    logic            busy_out;

    // Sequencer side
    modport slave (
        input  trap_valid_in, trap_pc_in, trap_cause_in, trap_tval_in, mret_valid_in,
        input  csru_read_name_in, csru_write_valid_in, csru_write_name_in, csru_write_data_in,
        input  csr_read_data_in,
        output trap_ready_out, mret_ready_out, csru_read_data_out, csru_stall_out,
        output csru_conflict_out, csr_read_name_out, csr_write_valid_out, csr_write_name_out,
        output csr_write_data_out, redirect_valid_out, redirect_addr_out, busy_out
    );

    // Environment side
    modport master (
        output trap_valid_in, trap_pc_in, trap_cause_in, trap_tval_in, mret_valid_in,
        output csru_read_name_in, csru_write_valid_in, csru_write_name_in, csru_write_data_in,
        output csr_read_data_in,
        input  trap_ready_out, mret_ready_out, csru_read_data_out, csru_stall_out,
        input  csru_conflict_out, csr_read_name_out, csr_write_valid_out, csr_write_name_out,
        input  csr_write_data_out, redirect_valid_out, redirect_addr_out, busy_out
    );
endinterface

// File: rtl/csr_trap_sequencer.sv
// Shares the CSR file ports between the CSR unit and trap/MRET sequencing:
// pass-through in IDLE, otherwise one machine-mode CSR write per cycle then a redirect.
module csr_trap_sequencer #(parameter int XLEN = 64) (
    input  logic                 clock,
    input  logic                 reset,
    csr_trap_sequencer_if.slave  bus
);
    localparam logic [11:0] MSTATUS = 12'h300;
    localparam logic [11:0] MTVEC   = 12'h305;
    localparam logic [11:0] MEPC    = 12'h341;
    localparam logic [11:0] MCAUSE  = 12'h342;
    localparam logic [11:0] MTVAL   = 12'h343;

    typedef enum logic [2:0] {
        IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_VEC, R_STATUS, R_EPC
    } state_t;

    state_t          r_state, w_next;
    logic [XLEN-1:0] r_pc, r_cause, r_tval, r_redir_addr;
    logic            r_redir_vld, r_conflict;

    logic            w_idle, w_trap_acc, w_mret_acc, w_redir_set;
    logic [XLEN-1:0] w_base, w_off, w_trap_tgt, w_redir_tgt, w_st_trap, w_st_mret;
    logic [11:0]     w_rd_name, w_wr_name;
    logic [XLEN-1:0] w_wr_data;
    logic            w_wr_vld;

    assign w_idle     = (r_state == IDLE);
    assign w_trap_acc = w_idle && bus.trap_valid_in;
    assign w_mret_acc = w_idle && !bus.trap_valid_in && bus.mret_valid_in;

    // Vectored mode only applies to interrupts (cause MSB set)
    assign w_base     = {bus.csr_read_data_in[XLEN-1:2], 2'b00};
    assign w_off      = {1'b0, r_cause[XLEN-2:0]} << 2;
    assign w_trap_tgt = (bus.csr_read_data_in[1:0] == 2'b01 && r_cause[XLEN-1])
                        ? (w_base + w_off) : w_base;

    always_comb begin
        w_st_trap        = bus.csr_read_data_in;
        w_st_trap[7]     = bus.csr_read_data_in[3];
        w_st_trap[3]     = 1'b0;
        w_st_trap[12:11] = 2'b11;
        w_st_mret        = bus.csr_read_data_in;
        w_st_mret[3]     = bus.csr_read_data_in[7];
        w_st_mret[7]     = 1'b1;
        w_st_mret[12:11] = 2'b00;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_pc         <= '0;
            r_cause      <= '0;
            r_tval       <= '0;
            r_redir_vld  <= 1'b0;
            r_redir_addr <= '0;
            r_conflict   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_redir_vld <= w_redir_set;
            r_conflict  <= bus.csru_write_valid_in && !w_idle;
            if (w_redir_set) r_redir_addr <= w_redir_tgt;
            if (w_trap_acc) begin
                r_pc    <= bus.trap_pc_in;
                r_cause <= bus.trap_cause_in;
                r_tval  <= bus.trap_tval_in;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_rd_name   = bus.csru_read_name_in;
        w_wr_vld    = 1'b0;
        w_wr_name   = '0;
        w_wr_data   = '0;
        w_redir_set = 1'b0;
        w_redir_tgt = '0;
        case (r_state)
            IDLE: begin
                w_wr_vld  = bus.csru_write_valid_in;
                w_wr_name = bus.csru_write_name_in;
                w_wr_data = bus.csru_write_data_in;
                if (w_trap_acc)      w_next = T_EPC;
                else if (w_mret_acc) w_next = R_STATUS;
            end
            T_EPC: begin
                w_wr_vld = 1'b1; w_wr_name = MEPC; w_wr_data = r_pc;
                w_next = T_CAUSE;
            end
            T_CAUSE: begin
                w_wr_vld = 1'b1; w_wr_name = MCAUSE; w_wr_data = r_cause;
                w_next = T_TVAL;
            end
            T_TVAL: begin
                w_wr_vld = 1'b1; w_wr_name = MTVAL; w_wr_data = r_tval;
                w_next = T_STATUS;
            end
            T_STATUS: begin
                w_rd_name = MSTATUS;
                w_wr_vld = 1'b1; w_wr_name = MSTATUS; w_wr_data = w_st_trap;
                w_next = T_VEC;
            end
            T_VEC: begin
                w_rd_name   = MTVEC;
                w_redir_set = 1'b1;
                w_redir_tgt = w_trap_tgt;
                w_next      = IDLE;
            end
            R_STATUS: begin
                w_rd_name = MSTATUS;
                w_wr_vld = 1'b1; w_wr_name = MSTATUS; w_wr_data = w_st_mret;
                w_next = R_EPC;
            end
            R_EPC: begin
                w_rd_name   = MEPC;
                w_redir_set = 1'b1;
                w_redir_tgt = {bus.csr_read_data_in[XLEN-1:2], 2'b00};
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.trap_ready_out      = w_idle;
    assign bus.mret_ready_out      = w_idle && !bus.trap_valid_in;
    assign bus.csru_read_data_out  = bus.csr_read_data_in;
    assign bus.csru_stall_out      = !w_idle;
    assign bus.busy_out            = !w_idle;
    assign bus.csru_conflict_out   = r_conflict;
    assign bus.csr_read_name_out   = w_rd_name;
    assign bus.csr_write_valid_out = w_wr_vld;
    assign bus.csr_write_name_out  = w_wr_name;
    assign bus.csr_write_data_out  = w_wr_data;
    assign bus.redirect_valid_out  = r_redir_vld;
    assign bus.redirect_addr_out   = r_redir_addr;
endmodule
